// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// State/ALU-op enums, opcode/funct values and datapath mux select codes.
package mc_ctrl_pkg;

   typedef enum logic [5:0] {
      S_FETCH     = 6'd0,
      S_DECODE    = 6'd1,
      S_EXEC_R    = 6'd2,
      S_WB_R      = 6'd3,
      S_EXEC_I    = 6'd4,
      S_WB_I      = 6'd5,
      S_MEM_ADDR  = 6'd6,
      S_MEM_READ  = 6'd7,
      S_MEM_WB    = 6'd8,
      S_MEM_WRITE = 6'd9,
      S_BRANCH    = 6'd10,
      S_LUI       = 6'd11,
      S_JUMP      = 6'd12,
      S_JAL       = 6'd13,
      S_JR        = 6'd14,
      S_ILLEGAL   = 6'd15,
      S_HALT      = 6'd16
   } state_t;

   typedef enum logic [2:0] {
      ALU_LOAD = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_INC  = 3'd4,
      ALU_NEG  = 3'd5,
      ALU_XOR  = 3'd6,
      ALU_COMP = 3'd7
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                          OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW  = 6'h2B;

   localparam logic [5:0] FN_NOP = 6'h00, FN_JR  = 6'h08, FN_HALT = 6'h0D,
                          FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND  = 6'h24,
                          FN_XOR = 6'h26, FN_SLT = 6'h2A;

   localparam logic [1:0] PCSRC_ALU  = 2'd0, PCSRC_ALUOUT = 2'd1,
                          PCSRC_JUMP = 2'd2, PCSRC_REG_A  = 2'd3;
   localparam logic [1:0] SRCB_B   = 2'd0, SRCB_FOUR    = 2'd1,
                          SRCB_IMM = 2'd2, SRCB_IMM_SH2 = 2'd3;
   localparam logic [1:0] M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1,
                          M2R_LUI    = 2'd2, M2R_PC  = 2'd3;
   localparam logic [1:0] RDST_RT = 2'd0, RDST_RD = 2'd1, RDST_RA = 2'd2;

   function automatic alu_op_t funct_alu_op(logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_XOR:  return ALU_XOR;
         FN_SLT:  return ALU_COMP;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM (master) and the multicycle datapath (slave).
interface multicycle_control_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       Zero_flag;
   logic       PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite;
   logic       AWrite, BWrite, AluOutWrite, MDRWrite;
   logic [1:0] PCSource, AluSrcB, MemtoReg, RegDst;
   logic [2:0] ALUOpOut;
   logic [5:0] State_out;
   logic       Illegal, Halted;

   modport master (
      input  opcode, funct, Zero_flag,
      output PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite,
             AWrite, BWrite, AluOutWrite, MDRWrite,
             PCSource, AluSrcB, MemtoReg, RegDst, ALUOpOut, State_out, Illegal, Halted
   );

   modport slave (
      output opcode, funct, Zero_flag,
      input  PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite,
             AWrite, BWrite, AluOutWrite, MDRWrite,
             PCSource, AluSrcB, MemtoReg, RegDst, ALUOpOut, State_out, Illegal, Halted
   );
endinterface

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter: counts up while enabled, done once it reaches MAX.
module mc_wait_counter #(
   parameter int unsigned MAX = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);
   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)       count_d = 4'd0;
      else if (enable) count_d = count_q + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset) count_q <= 4'd0;
      else        count_q <= count_d;
   end

   assign done = (count_q == 4'(MAX));
endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and drives every datapath select and write enable.
module multicycle_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT        = 2,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   multicycle_control_fsm_if.master bus
);
   state_t     state_q, state_d;
   logic       illegal_hold_q, illegal_hold_d;
   logic       wait_done, wait_en, wait_clr;
   logic       pc_write, iord, mem_rw, ir_write, alu_src_a, reg_write;
   logic       a_write, b_write, alu_out_write, mdr_write;
   logic [1:0] pc_source, alu_src_b, mem_to_reg, reg_dst;
   alu_op_t    alu_op;

   // Counter restarts whenever the state changes, so each access counts from 0.
   assign wait_en  = is_wait_state(state_q);
   assign wait_clr = (state_d != state_q);

   mc_wait_counter #(.MAX(MEM_WAIT)) u_wait (
      .clock  (clock),
      .reset  (reset),
      .clear  (wait_clr),
      .enable (wait_en),
      .done   (wait_done)
   );

   always_comb begin
      state_d        = state_q;
      illegal_hold_d = illegal_hold_q;
      case (state_q)
         S_FETCH:     if (wait_done) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  case (bus.funct)
                     FN_ADD, FN_SUB, FN_AND, FN_XOR, FN_SLT: state_d = S_EXEC_R;
                     FN_JR:   state_d = S_JR;
                     FN_NOP:  state_d = S_FETCH;
                     FN_HALT: state_d = S_HALT;
                     default: state_d = S_ILLEGAL;
                  endcase
               end
               OP_ADDI:        state_d = S_EXEC_I;
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_LUI:         state_d = S_LUI;
               OP_J:           state_d = S_JUMP;
               OP_JAL:         state_d = S_JAL;
               default:        state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:    state_d = S_WB_R;
         S_EXEC_I:    state_d = S_WB_I;
         S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
         S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
         S_ILLEGAL: begin
            if (HALT_ON_ILLEGAL) begin
               state_d        = S_HALT;
               illegal_hold_d = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= S_FETCH;
         illegal_hold_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         illegal_hold_q <= illegal_hold_d;
      end
   end

   always_comb begin
      pc_write = 1'b0; iord = 1'b0; mem_rw = 1'b0; ir_write = 1'b0;
      alu_src_a = 1'b0; reg_write = 1'b0; a_write = 1'b0; b_write = 1'b0;
      alu_out_write = 1'b0; mdr_write = 1'b0;
      pc_source = PCSRC_ALU; alu_src_b = SRCB_B; mem_to_reg = M2R_ALUOUT;
      reg_dst = RDST_RT; alu_op = ALU_LOAD;
      case (state_q)
         S_FETCH: begin
            alu_src_b = SRCB_FOUR; alu_op = ALU_ADD; mdr_write = 1'b1;
            if (wait_done) begin
               pc_write = 1'b1; ir_write = 1'b1; a_write = 1'b1; b_write = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2; alu_op = ALU_ADD; alu_out_write = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1; alu_op = funct_alu_op(bus.funct); alu_out_write = 1'b1;
         end
         S_WB_R:      begin reg_write = 1'b1; reg_dst = RDST_RD; end
         S_EXEC_I, S_MEM_ADDR: begin
            alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALU_ADD; alu_out_write = 1'b1;
         end
         S_WB_I:      reg_write = 1'b1;
         S_MEM_READ:  begin iord = 1'b1; mdr_write = 1'b1; end
         S_MEM_WB:    begin reg_write = 1'b1; mem_to_reg = M2R_MDR; end
         // A single write strobe on the last wait cycle, address held throughout.
         S_MEM_WRITE: begin iord = 1'b1; mem_rw = wait_done; end
         S_BRANCH: begin
            alu_src_a = 1'b1; alu_op = ALU_SUB; pc_source = PCSRC_ALUOUT;
            pc_write  = ((bus.opcode == OP_BEQ) &&  bus.Zero_flag) ||
                        ((bus.opcode == OP_BNE) && !bus.Zero_flag);
         end
         S_LUI:       begin reg_write = 1'b1; mem_to_reg = M2R_LUI; end
         S_JUMP:      begin pc_write = 1'b1; pc_source = PCSRC_JUMP; end
         // Link and jump share a cycle: the register file samples PC+4 before PC moves.
         S_JAL: begin
            reg_write = 1'b1; reg_dst = RDST_RA; mem_to_reg = M2R_PC;
            pc_write  = 1'b1; pc_source = PCSRC_JUMP;
         end
         S_JR:        begin pc_write = 1'b1; pc_source = PCSRC_REG_A; end
         default: ;
      endcase
   end

   assign bus.PCWrite      = pc_write & reset;
   assign bus.MemReadWrite = mem_rw & reset;
   assign bus.IRWrite      = ir_write & reset;
   assign bus.RegWrite     = reg_write & reset;
   assign bus.AWrite       = a_write & reset;
   assign bus.BWrite       = b_write & reset;
   assign bus.AluOutWrite  = alu_out_write & reset;
   assign bus.MDRWrite     = mdr_write & reset;
   assign bus.IorD         = iord;
   assign bus.AluSrcA      = alu_src_a;
   assign bus.PCSource     = pc_source;
   assign bus.AluSrcB      = alu_src_b;
   assign bus.MemtoReg     = mem_to_reg;
   assign bus.RegDst       = reg_dst;
   assign bus.ALUOpOut     = alu_op;
   assign bus.State_out    = state_q;
   assign bus.Illegal      = (state_q == S_ILLEGAL) || ((state_q == S_HALT) && illegal_hold_q);
   assign bus.Halted       = (state_q == S_HALT);
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Parametrised next-generation control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back, with a single configurable memory wait-state counter instead of hard-wired wait states. It adds addi, slt, jal, jr and an illegal-instruction path to the existing R/I/J subset. It sits beside the datapath and drives every mux select and register write enable.

Parameters:
MEM_WAIT, 2, extra wait cycles for each memory access (fetch, load, store); legal range 0..15.
HALT_ON_ILLEGAL, 0, 1 = an illegal opcode/funct enters HALT; 0 = flag it and refetch.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
Zero_flag  in  1  ALU zero result, combinational, same cycle
PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, AWrite, BWrite, AluOutWrite, MDRWrite  out  1 each  datapath controls; MemReadWrite 1 = write
PCSource  out  2  0 ALU, 1 AluOut, 2 jump target, 3 A register (jr)
AluSrcB  out  2  0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
MemtoReg  out  2  0 AluOut, 1 MDR, 2 imm<<16, 3 PC (jal)
RegDst  out  2  0 rt, 1 rd, 2 const 31
ALUOpOut  out  3  LOAD=0 ADD=1 SUB=2 AND=3 INC=4 NEG=5 XOR=6 COMP=7 (set-less-than)
State_out  out  6  current state encoding
Illegal  out  1  high for the ILLEGAL cycle; held high in HALT if entered from ILLEGAL
Halted  out  1  high while in HALT

Behaviour:
- Outputs are combinational from the state and the wait counter. While reset=0, every write enable and MemReadWrite is forced to 0. On the clock edge with reset=0: state<=FETCH, wait_cnt<=0.
- FETCH: IorD=0, MemReadWrite=0, AluSrcA=0, AluSrcB=1, ALUOp=ADD, MDRWrite=1.
  - wait_cnt counts 0..MEM_WAIT.
  - On the cycle wait_cnt==MEM_WAIT: PCWrite=1, IRWrite=1, AWrite=BWrite=1, PCSource=0, counter cleared, next state DECODE.
  - Fetch latency = MEM_WAIT+1 cycles. With MEM_WAIT=0 FETCH lasts exactly 1 cycle.
- DECODE: AluSrcA=0, AluSrcB=3, ADD, AluOutWrite=1 (branch target). Dispatch:
  - opcode 0 with funct 20/22/24/26/2A -> EXEC_R
  - opcode 0 with funct 08 -> JR; funct 00 -> FETCH (nop); funct 0D -> HALT
  - 08 -> EXEC_I; 23/2B -> MEM_ADDR; 04/05 -> BRANCH; 0F -> LUI; 02 -> JUMP; 03 -> JAL
  - anything else -> ILLEGAL
- EXEC_R: AluSrcA=1, AluSrcB=0, AluOutWrite=1. ALUOp from funct: 20 ADD, 22 SUB, 24 AND, 26 XOR, 2A COMP. Next state WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- EXEC_I: AluSrcA=1, AluSrcB=2, ADD, AluOutWrite=1 -> WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=2, ADD, AluOutWrite=1, one cycle. Next state MEM_READ for 23, MEM_WRITE for 2B.
- MEM_READ: IorD=1, MemReadWrite=0, MDRWrite=1. Waits MEM_WAIT+1 cycles -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEM_WRITE: IorD=1 for MEM_WAIT+1 cycles. MemReadWrite=1 only on the final cycle, so there is exactly one write strobe -> FETCH.
- BRANCH: AluSrcA=1, AluSrcB=0, SUB, PCSource=1. PCWrite = (opcode==04 & Zero_flag) | (opcode==05 & ~Zero_flag). Next state FETCH.
- LUI: RegWrite=1, RegDst=0, MemtoReg=2 -> FETCH.
- JUMP: PCWrite=1, PCSource=2 -> FETCH.
- JAL: RegWrite=1, RegDst=2, MemtoReg=3, PCWrite=1, PCSource=2, all in one cycle. The register file captures the old PC+4 before the PC update -> FETCH.
- JR: PCWrite=1, PCSource=3 -> FETCH.
- ILLEGAL: one cycle, Illegal=1, no writes. Next state HALT if HALT_ON_ILLEGAL=1, else FETCH.
- HALT: all enables 0, Halted=1. Only reset exits HALT.
- Inactive selects drive 0, never X.
- wait_cnt is cleared on every state change.
- Reset low mid-access aborts immediately, with no partial write.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (6-bit)
  - ALU-op enum (3-bit)
  - opcode/funct localparams
  - PCSource/MemtoReg/RegDst/AluSrcB select constants
- Sub-module mc_wait_counter (param MAX): inputs clear and enable; output done when count==MAX.

Test Plan:
- MEM_WAIT=2, add (op 0, funct 20): FETCH 3 cycles with PCWrite/IRWrite only on the 3rd, then DECODE, EXEC_R ALUOp=1, WB_R RegWrite=1 RegDst=1; 6 cycles total.
- MEM_WAIT=0, lw (op 23): FETCH 1, DECODE, MEM_ADDR, MEM_READ 1 cycle, MEM_WB MemtoReg=1 RegWrite=1; 5 cycles total.
- MEM_WAIT=3, sw (op 2B): MEM_WRITE lasts 4 cycles with MemReadWrite=1 only on the 4th.
- beq with Zero_flag=1 -> PCWrite=1 PCSource=1; bne with Zero_flag=1 -> PCWrite=0; bne with Zero_flag=0 -> PCWrite=1.
- jal (op 03): one cycle with RegDst=2, MemtoReg=3, RegWrite=1, PCWrite=1, PCSource=2; jr (op 0, funct 08): PCSource=3.
- op 3F with HALT_ON_ILLEGAL=0: Illegal pulses 1 cycle, then FETCH. With HALT_ON_ILLEGAL=1: Halted stays 1 until reset=0; reset asserted mid-MEM_WRITE gives no write strobe and the next state is FETCH.
